// File: rtl/pool_tile_ctrl_pkg.sv
// Shared definitions for the pooling tile controller: FSM encoding and data geometry.
package pool_tile_ctrl_pkg;

  localparam int WORD_W     = 16;
  localparam int TILE_WORDS = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/pool_tile_ctrl_addr_fifo.sv
// Small address FIFO between the pooling address generator and the memory read port.
module pool_addr_fifo
  import pool_tile_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is reset too so the read port shows zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pool_tile_ctrl.sv
// Sequences tiled max-pooling: drives the address generator, issues single-outstanding
// reads through a small address FIFO, and reduces each WIN-word window to its unsigned max.
module pool_tile_ctrl
  import pool_tile_ctrl_pkg::*;
#(
  parameter int WIN           = 4,
  parameter int OUTS_PER_TILE = TILE_WORDS / WIN,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_tiles,
  output logic              busy,
  output logic              done,
  output logic              ag_rst,
  output logic              ag_en,
  input  logic [WORD_W-1:0] ag_addr,
  input  logic              ag_valid,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              error
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]     EN_LIM     = CW'(FIFO_DEPTH - 2);
  localparam logic [WORD_W-1:0] TILE_ADDRS = WORD_W'(WIN * OUTS_PER_TILE);
  localparam logic [WORD_W-1:0] LAST_OUT   = WORD_W'(OUTS_PER_TILE - 1);
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WIN - 1);

  state_t            state, state_nxt;
  logic [7:0]        num_q;
  logic [WORD_W-1:0] tile_cnt, addr_cnt, out_cnt, word_cnt;
  logic [WORD_W-1:0] acc, win_max;
  logic              outstanding, req_hold;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic accept, rd_ok, tile_end, job_end;

  assign fifo_push = ag_valid && (state == ST_RUN);
  assign fifo_pop  = mem_req && mem_gnt;
  assign accept    = out_valid && out_ready;
  assign rd_ok     = mem_rvalid && outstanding;
  assign tile_end  = accept && (out_cnt == LAST_OUT);
  assign job_end   = tile_end && ((tile_cnt + 16'd1) == {8'd0, num_q});
  assign win_max   = (word_cnt == '0 || mem_rdata > acc) ? mem_rdata : acc;

  pool_addr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ag_addr),
    .dout  (mem_addr),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_tiles == 8'd0) ? ST_DONE : ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_RUN;
      ST_RUN:    if (job_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A request that was not granted is held so address and strobe stay put until taken.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ag_rst  = 1'b0;
    ag_en   = 1'b0;
    mem_req = 1'b0;
    case (state)
      ST_LAUNCH: begin
        busy   = 1'b1;
        ag_rst = 1'b1;
      end
      ST_RUN: begin
        busy    = 1'b1;
        ag_en   = (fifo_count <= EN_LIM) && (addr_cnt < TILE_ADDRS);
        mem_req = req_hold ||
                  (!fifo_empty && (!outstanding || mem_rvalid) && (!out_valid || out_ready));
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q       <= '0;
      tile_cnt    <= '0;
      addr_cnt    <= '0;
      out_cnt     <= '0;
      word_cnt    <= '0;
      acc         <= '0;
      outstanding <= 1'b0;
      req_hold    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      error       <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) num_q <= num_tiles;

      if (state == ST_IDLE) begin
        tile_cnt <= '0;
        addr_cnt <= '0;
        out_cnt  <= '0;
      end else begin
        if (tile_end) begin
          tile_cnt <= tile_cnt + 16'd1;
          addr_cnt <= '0;
        end else if (fifo_push) begin
          addr_cnt <= addr_cnt + 16'd1;
        end
        if (accept) out_cnt <= (out_cnt == LAST_OUT) ? '0 : out_cnt + 16'd1;
      end

      if (mem_req && mem_gnt) outstanding <= 1'b1;
      else if (mem_rvalid)    outstanding <= 1'b0;
      req_hold <= mem_req && !mem_gnt;

      if ((mem_rvalid && !outstanding) || (ag_valid && fifo_full)) error <= 1'b1;

      if (rd_ok) begin
        acc      <= win_max;
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 16'd1;
      end

      if (rd_ok && word_cnt == LAST_WORD) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pool_tile_ctrl.md
POOL_TILE_CTRL -- requirements
Module: pool_tile_ctrl

Interface
REQ-001 SHALL have parameter WIN, default 4: read words per pooling window.
REQ-002 SHALL have parameter OUTS_PER_TILE, default 25: pooled results per 100-word tile.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: address buffer entries.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  job start pulse.
REQ-007 num_tiles  in  8  tiles in job; latched at accepted start.
REQ-008 busy  out  1  job in progress.
REQ-009 done  out  1  one-cycle job-complete pulse.
REQ-010 ag_rst  out  1  restart pulse to pooling address generator.
REQ-011 ag_en  out  1  enable (i_valid) to address generator.
REQ-012 ag_addr  in  16  generated address; ag_valid  in  1  address strobe.
REQ-013 mem_req  out  1  read request; mem_addr  out  16  read address; mem_gnt  in  1  grant.
REQ-014 mem_rdata  in  16  read data; mem_rvalid  in  1  data strobe, exactly one cycle after grant.
REQ-015 out_data  out  16  pooled max; out_valid  out  1; out_ready  in  1.
REQ-016 error  out  1  sticky fault flag.

Function
REQ-017 FSM states IDLE, LAUNCH, RUN, DONE; IDLE->LAUNCH on start; LAUNCH->RUN after 1 cycle; RUN->DONE after last result of last tile accepted; DONE->IDLE after 1 cycle.
REQ-018 start in IDLE with num_tiles==0 SHALL go directly to DONE; start outside IDLE SHALL be ignored.
REQ-019 busy=1 in LAUNCH and RUN; done=1 only in DONE; ag_rst=1 only in LAUNCH.
REQ-020 ag_valid addresses SHALL be pushed into a FIFO_DEPTH-entry FIFO; ag_en=1 in RUN only while FIFO count <= FIFO_DEPTH-2 and tile address count < WIN*OUTS_PER_TILE.
REQ-021 ag_valid with FIFO full SHALL drop the address and set error.
REQ-022 mem_req=1 while FIFO non-empty, no read outstanding (or rvalid this cycle), and output register free or being accepted; mem_addr=FIFO head; FIFO pop on mem_req&&mem_gnt.
REQ-023 mem_req/mem_addr SHALL hold stable until granted.
REQ-024 At most one read outstanding; mem_rvalid with none outstanding SHALL set error and be ignored.
REQ-025 Accumulator: unsigned max over WIN rvalids; first word of window loads directly.
REQ-026 out_data/out_valid SHALL assert the cycle after the WIN-th rvalid; hold stable until out_valid&&out_ready.
REQ-027 Per-tile address count clears, and tile_cnt increments, on acceptance of the OUTS_PER_TILE-th result; ag_rst not pulsed between tiles.
REQ-028 Job complete when tile_cnt reaches latched num_tiles; no further ag_en or mem_req.
REQ-029 Counters 16-bit internal, no wrap within a job (num_tiles<=255, WIN*OUTS_PER_TILE<=65535).

Reset
REQ-030 rst SHALL force IDLE, clear FIFO, counters, accumulator, outstanding flag, error.
REQ-031 Reset values: busy, done, ag_rst, ag_en, mem_req, out_valid, error = 0; mem_addr, out_data = 0.
REQ-032 rst mid-job SHALL abandon the job immediately; late mem_rvalid after rst SHALL set error.

Structure
REQ-033 Shared package SHALL hold FSM state enum, word width 16, tile size 100.
REQ-034 Address FIFO SHALL be sub-module pool_addr_fifo (push, pop, count, full, empty).

Verification
REQ-035 num_tiles=1, mem_gnt=1 always, out_ready=1, data = address -> 25 results, each = max address of its window; done once; error=0.
REQ-036 num_tiles=0 start -> done pulse 1 cycle later, no ag_en, no mem_req.
REQ-037 mem_gnt low 5 cycles with request pending -> mem_addr stable, FIFO stops at count 2-3, no drop, error=0.
REQ-038 out_ready=0 for 20 cycles mid-tile -> out_data held, no mem_req issued, resumes with no lost result.
REQ-039 num_tiles=3 -> exactly 75 results, 300 grants, single ag_rst pulse, done after 75th accept.
REQ-040 Spurious mem_rvalid in IDLE -> error=1 stays until rst; rst mid-job -> all outputs 0 next cycle.
